// File: rtl/lsu_stbuf.sv
// Store buffer between the LSU and an AHB-Lite master port: queues aligned stores and drains them one at a time.
// Optional LSU_STBUF_ECC_EN stores a per-entry SECDED checksum that is driven on s_hwdcheck_o.
module lsu_stbuf #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32
) (
  input  logic                     s_clk_i,
  input  logic                     s_rst_i,
  input  logic                     s_push_i,
  input  logic [AW-1:0]            s_push_addr_i,
  input  logic [31:0]              s_push_data_i,
  input  logic [1:0]               s_push_size_i,
  output logic                     s_full_o,
  input  logic                     s_ld_valid_i,
  input  logic [AW-1:0]            s_ld_addr_i,
  output logic                     s_ld_hazard_o,
  output logic [AW-1:0]            s_haddr_o,
  output logic [31:0]              s_hwdata_o,
  output logic [6:0]               s_hwdcheck_o,
  output logic [2:0]               s_hsize_o,
  output logic [1:0]               s_htrans_o,
  output logic                     s_hwrite_o,
  input  logic                     s_hready_i,
  input  logic                     s_hresp_i,
  output logic                     s_empty_o,
  output logic [$clog2(DEPTH):0]   s_count_o,
  output logic                     s_err_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_q, rd_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DEPTH-1:0] valid_q;
  logic            err_q, err_pend_q;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [31:0]     data_q [DEPTH];
  logic [1:0]      size_q [DEPTH];

  logic            push_ok, pop, err_now;
  logic [31:0]     aligned;
  logic            hazard;
  logic            unused_ld_lsb;

  assign unused_ld_lsb = ^s_ld_addr_i[1:0];

`ifdef LSU_STBUF_ECC_EN
  logic [6:0] ecc_q [DEPTH];

  // Hamming over codeword positions 1..38 (data skips powers of two) plus overall parity.
  function automatic logic [6:0] secded(input logic [31:0] d);
    logic [6:0] c;
    logic [5:0] k;
    c = '0;
    k = '0;
    for (int unsigned p = 3; p < 39; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (d[k[4:0]]) c[5:0] = c[5:0] ^ 6'(p);
        k = k + 6'd1;
      end
    end
    c[6] = ^{d, c[5:0]};
    return c;
  endfunction
`endif

  assign s_full_o  = (count_q == CW'(DEPTH));
  assign s_empty_o = (count_q == '0);
  assign s_count_o = count_q;
  assign s_err_o   = err_q;

  assign push_ok = s_push_i & ~s_full_o;
  // An errored head is discarded on its completing cycle exactly like a normal pop.
  assign pop     = (state_q == DATA) & s_hready_i;
  assign err_now = pop & (s_hresp_i | err_pend_q);

  always_comb begin
    aligned = s_push_data_i;
    case (s_push_size_i)
      2'd0:    aligned = {4{s_push_data_i[7:0]}};
      2'd1:    aligned = {2{s_push_data_i[15:0]}};
      default: aligned = s_push_data_i;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_ok) count_d = count_q - CW'(1);
  end

  // The incoming push counts in IDLE so the address phase follows the push by one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_hready_i && (!s_empty_o || push_ok)) state_d = ADDR;
      ADDR:    if (s_hready_i) state_d = DATA;
      DATA:    if (s_hready_i) state_d = (count_d != '0) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge s_clk_i) begin
    if (s_rst_i) begin
      state_q    <= IDLE;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_now;
      if (push_ok) begin
        valid_q[wr_q] <= 1'b1;
        wr_q          <= wr_q + PW'(1);
      end
      if (pop) begin
        valid_q[rd_q] <= 1'b0;
        rd_q          <= rd_q + PW'(1);
        err_pend_q    <= 1'b0;
      end else if (state_q == DATA && s_hresp_i) begin
        err_pend_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk_i) begin
    if (push_ok) begin
      addr_q[wr_q] <= s_push_addr_i;
      data_q[wr_q] <= aligned;
      size_q[wr_q] <= s_push_size_i;
`ifdef LSU_STBUF_ECC_EN
      ecc_q[wr_q]  <= secded(aligned);
`endif
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && addr_q[i][AW-1:2] == s_ld_addr_i[AW-1:2]) hazard = 1'b1;
    end
  end

  assign s_ld_hazard_o = s_ld_valid_i & hazard;

  always_comb begin
    s_haddr_o    = '0;
    s_hwdata_o   = '0;
    s_hwdcheck_o = '0;
    s_hsize_o    = '0;
    s_htrans_o   = 2'b00;
    s_hwrite_o   = 1'b0;
    case (state_q)
      ADDR: begin
        s_htrans_o = 2'b10;
        s_hwrite_o = 1'b1;
        s_haddr_o  = addr_q[rd_q];
        s_hsize_o  = {1'b0, size_q[rd_q]};
      end
      DATA: begin
        s_hwdata_o = data_q[rd_q];
`ifdef LSU_STBUF_ECC_EN
        s_hwdcheck_o = ecc_q[rd_q];
`endif
      end
      default: ;
    endcase
  end

endmodule
